// File: rtl/imm_seq_ctrl_pkg.sv
// Shared types for the immediate-sequencing controller.
// Holds the immediate-format enum, RV32I major opcodes, buffer FSM states
// and the stored buffer entry layout.
package imm_seq_ctrl_pkg;

  // Immediate formats, 3-bit encoding visible on out_imm_type.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Skid-buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // One buffered instruction, decoded at capture time.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  imm_type;
`ifdef IMM_ILLEGAL_EN
    logic        illegal;
`endif
  } entry_t;

endpackage

// File: rtl/imm_seq_ctrl_imm_ext.sv
// imm_ext: combinational RV32I immediate extractor (opcode -> format -> imm).
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: instr in; imm_type, imm out; illegal out only with IMM_ILLEGAL_EN.
module imm_ext
  import imm_seq_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  imm_type,
  output logic [31:0] imm
`ifdef IMM_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  logic illegal_c;

  always_comb begin
    imm_type  = IMM_NONE;
    imm       = 32'd0;
    illegal_c = 1'b0;
    unique case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        imm      = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        imm      = {instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      end
      OPC_OP: begin
        imm_type = IMM_NONE;
      end
      default: begin
        // Unknown opcode: format NONE with zero immediate either way.
        illegal_c = 1'b1;
      end
    endcase
  end

`ifdef IMM_ILLEGAL_EN
  assign illegal = illegal_c;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_c;
`endif

endmodule

// File: rtl/imm_seq_ctrl.sv
// imm_seq_ctrl: 2-entry skid buffer between fetch and execute carrying
// pre-decoded RV32I immediates. Latency: 1 cycle from accept to out_* when
// empty or popping. Backpressure: in_ready drops only when both entries are
// full; it is a decode of the state register, never of out_ready.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_instr/in_pc;
// flush; out_valid/out_ready/out_instr/out_pc/out_imm/out_imm_type;
// out_illegal exists only when IMM_ILLEGAL_EN is defined.
module imm_seq_ctrl
  import imm_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [2:0]  out_imm_type
`ifdef IMM_ILLEGAL_EN
  ,
  output logic        out_illegal
`endif
);

  buf_state_t state, state_nxt;
  entry_t     head, tail, new_ent;
  logic       accept, pop;

  // Decode once at capture so the outputs come straight from storage.
  imm_ext u_imm_ext (
    .instr    (in_instr),
    .imm_type (new_ent.imm_type),
    .imm      (new_ent.imm)
`ifdef IMM_ILLEGAL_EN
    ,
    .illegal  (new_ent.illegal)
`endif
  );
  assign new_ent.instr = in_instr;
  assign new_ent.pc    = in_pc;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush wins over any accept/pop this cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state_nxt = ST_TWO;
          else if (!accept && pop) state_nxt = ST_EMPTY;
        end
        ST_TWO: if (pop) state_nxt = ST_ONE;
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Outputs are functions of the state register only.
  always_comb begin
    out_valid = (state != ST_EMPTY);
    in_ready  = (state != ST_TWO);
  end

  // Entry storage. Vacated slots are zeroed so an empty buffer presents
  // all-zero data without any output gating.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) head <= new_ent;
        end
        ST_ONE: begin
          if (accept && pop)  head <= new_ent;
          else if (accept)    tail <= new_ent;
          else if (pop)       head <= '0;
        end
        ST_TWO: begin
          if (pop) begin
            head <= tail;
            tail <= '0;
          end
        end
        default: begin
          head <= '0;
          tail <= '0;
        end
      endcase
    end
  end

  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_imm      = head.imm;
  assign out_imm_type = head.imm_type;
`ifdef IMM_ILLEGAL_EN
  assign out_illegal  = head.illegal;
`endif

endmodule
